// File: rtl/fetch_buffer_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_buffer_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busy;

  modport master (output imem_ren, output imem_addr, input imem_rdata, input imem_busy);
  modport slave  (input imem_ren, input imem_addr, output imem_rdata, output imem_busy);
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage with a DEPTH-entry prefetch queue of {pc, instr, fault}, redirect
// flush with in-flight squash, and in-band misaligned-PC fault entries.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       CLK,
  input  logic                       nRST,
  fetch_buffer_if.master             imem,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  input  logic                       pc_en,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  output logic                       instr_valid,
  output logic                       instr_fault,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, WAIT, SQUASH, FAULT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   squash_addr;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          q_fault [DEPTH];

  logic          issue;
  logic          done;
  logic          deq;
  logic          enq_word;
  logic          enq_fault;
  logic          enq;
  logic [CW-1:0] count_next;

  // A misaligned PC in RUN never reaches the bus; that cycle enqueues the fault entry instead.
  assign issue          = (state == RUN) && (fetch_pc[1:0] == 2'b00);
  assign imem.imem_ren  = issue || (state == SQUASH);
  assign imem.imem_addr = (state == SQUASH) ? squash_addr : fetch_pc;

  assign done      = imem.imem_ren && !imem.imem_busy;
  assign deq       = pc_en && (count != '0);
  assign enq_word  = issue && !imem.imem_busy;
  assign enq_fault = (state == RUN) && (fetch_pc[1:0] != 2'b00);
  assign enq       = enq_word || enq_fault;

  always_comb begin
    count_next = count;
    if (enq && !deq)
      count_next = count + 1'b1;
    else if (deq && !enq)
      count_next = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= WAIT;
      fetch_pc    <= RESET_PC;
      squash_addr <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      if (imem.imem_ren && imem.imem_busy) begin
        // The bus beat must finish at its original address; its data is dropped later.
        state       <= SQUASH;
        squash_addr <= imem.imem_addr;
      end else begin
        state <= halt ? WAIT : RUN;
      end
    end else begin
      if (enq) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= enq_word ? imem.imem_rdata : '0;
        q_fault[tail] <= enq_fault;
        tail          <= tail + 1'b1;
      end
      if (deq)
        head <= head + 1'b1;
      count <= count_next;

      case (state)
        RUN: begin
          if (enq_fault) begin
            state <= FAULT;
          end else if (done) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next == FULL || halt)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (count_next < FULL && !halt)
            state <= RUN;
        end
        SQUASH: begin
          if (done)
            state <= WAIT;
        end
        default: state <= state;
      endcase
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[head] : '0;
  assign instr_pc    = instr_valid ? q_pc[head]    : '0;
  assign instr_fault = instr_valid ? q_fault[head] : 1'b0;
  assign occupancy   = count;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: memory model returning addr as data, and a
// scoreboard queue of expected head entries checked every cycle.
module tb_fetch_buffer;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
  } ent_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        pc_en;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_fault;
  logic [2:0]  occupancy;

  fetch_buffer_if bus ();

  fetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc_en       (pc_en),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_fault (instr_fault),
    .occupancy   (occupancy)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lat    = 0;
  int unsigned wcnt   = 0;
  int unsigned ncomp  = 0;
  ent_t        sb[$];
  logic        sq        = 1'b0;
  logic        hold      = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        push_fault = 1'b0;
  logic [31:0] fault_pc   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory response, head/occupancy checks, edge, model update.
  task automatic step();
    logic        ren, busy, done, deq;
    logic [31:0] addr, data;
    ren  = bus.imem_ren;
    addr = bus.imem_addr;
    if (ren && wcnt < lat) begin
      bus.imem_busy = 1'b1;
      wcnt++;
    end else begin
      bus.imem_busy  = 1'b0;
      bus.imem_rdata = addr;
      if (!ren) wcnt = 0;
    end
    busy = bus.imem_busy;
    data = bus.imem_rdata;
    done = ren && !busy;

    if (hold) begin
      chk("ren_hold", ren, 1'b1);
      chk("addr_hold", addr, hold_addr);
    end
    chk("valid", instr_valid, sb.size() != 0);
    chk("occupancy", occupancy, 32'(sb.size()));
    if (sb.size() != 0) begin
      chk("head_pc", instr_pc, sb[0].pc);
      chk("head_instr", instr, sb[0].ins);
      chk("head_fault", instr_fault, sb[0].flt);
    end else begin
      chk("empty_instr", instr, 32'h0);
      chk("empty_pc", instr_pc, 32'h0);
    end
    deq = pc_en && (sb.size() != 0);

    @(posedge CLK);
    if (done) begin
      wcnt = 0;
      ncomp++;
    end
    if (!nRST) begin
      sb.delete();
      sq = 1'b0;
    end else if (redirect) begin
      sb.delete();
      sq = ren && busy;
    end else begin
      if (deq) void'(sb.pop_front());
      if (done) begin
        if (sq) sq = 1'b0;
        else    sb.push_back('{pc: addr, ins: data, flt: 1'b0});
      end
      if (push_fault) sb.push_back('{pc: fault_pc, ins: 32'h0, flt: 1'b1});
    end
    hold      = nRST && ren && busy;
    hold_addr = addr;
    #1;
  endtask

  task automatic wait_ren(input string tag);
    int unsigned n = 0;
    while (!bus.imem_ren && n < 20) begin
      step();
      n++;
    end
    chk(tag, bus.imem_ren, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, instr_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] old_addr;
    nRST = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; pc_en = 1'b0;
    bus.imem_busy = 1'b0; bus.imem_rdata = '0;

    @(posedge CLK); #1;
    chk("rst_ren", bus.imem_ren, 1'b0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_occ", occupancy, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", instr_fault, 1'b0);

    // Zero-wait streaming with pc_en held high
    nRST = 1'b1; pc_en = 1'b1;
    step();
    chk("first_ren", bus.imem_ren, 1'b1);
    chk("first_addr", bus.imem_addr, RST_PC);
    step();
    chk("seq0_pc", instr_pc, RST_PC);
    chk("seq0_instr", instr, RST_PC);
    step();
    chk("seq1_pc", instr_pc, RST_PC + 32'd4);
    step();
    chk("seq2_pc", instr_pc, RST_PC + 32'd8);
    for (int i = 0; i < 6; i++) begin
      chk("stream_ren", bus.imem_ren, 1'b1);
      step();
    end

    // Fill with no consumption, then one pulse of pc_en
    nRST = 1'b0; step(); nRST = 1'b1;
    pc_en = 1'b0; ncomp = 0;
    repeat (12) step();
    chk("fill_comps", ncomp, 32'd4);
    chk("fill_occ", occupancy, 32'd4);
    chk("fill_ren", bus.imem_ren, 1'b0);
    pc_en = 1'b1; step(); pc_en = 1'b0;
    repeat (6) step();
    chk("refill_comps", ncomp, 32'd5);
    chk("refill_occ", occupancy, 32'd4);
    chk("refill_ren", bus.imem_ren, 1'b0);

    // Redirect on the 2nd of 3 busy cycles squashes the in-flight beat
    lat = 3; pc_en = 1'b1;
    wait_ren("sq_start");
    old_addr = bus.imem_addr;
    step();
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect = 1'b0;
    chk("sq_addr_a", bus.imem_addr, old_addr);
    step();
    chk("sq_addr_b", bus.imem_addr, old_addr);
    step();
    lat = 0;
    step();
    wait_ren("sq_restart");
    chk("sq_new_addr", bus.imem_addr, 32'h8000_0100);
    wait_valid("sq_valid");
    chk("sq_first_pc", instr_pc, 32'h8000_0100);

    // Misaligned redirect target produces an in-band fault entry
    pc_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
    chk("flt_noreq", bus.imem_ren, 1'b0);
    fault_pc = 32'h8000_0102; push_fault = 1'b1;
    step();
    push_fault = 1'b0;
    chk("flt_valid", instr_valid, 1'b1);
    chk("flt_flag", instr_fault, 1'b1);
    chk("flt_pc", instr_pc, 32'h8000_0102);
    chk("flt_instr", instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flt_idle", bus.imem_ren, 1'b0);
    end
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect = 1'b0; pc_en = 1'b1;
    wait_ren("flt_resume");
    chk("flt_resume_addr", bus.imem_addr, 32'h8000_0200);
    wait_valid("flt_resume_valid");
    chk("flt_resume_pc", instr_pc, 32'h8000_0200);
    chk("flt_resume_flag", instr_fault, 1'b0);

    // Redirect coinciding with dequeue and completion at occupancy 2
    pc_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (occupancy == 3'd2 && bus.imem_ren) break;
      step();
    end
    chk("coin_setup_occ", occupancy, 32'd2);
    chk("coin_setup_ren", bus.imem_ren, 1'b1);
    pc_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect = 1'b0;
    chk("coin_occ", occupancy, 32'h0);
    chk("coin_valid", instr_valid, 1'b0);

    // Halt during a two-cycle request: word still enqueued, then fetch stops
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_ren && wcnt == 0) break;
      step();
    end
    chk("halt_setup", bus.imem_ren, 1'b1);
    old_addr = bus.imem_addr;
    halt = 1'b1;
    step();
    step();
    chk("halt_enq_pc", instr_pc, old_addr);
    for (int i = 0; i < 5; i++) begin
      chk("halt_idle", bus.imem_ren, 1'b0);
      step();
    end
    halt = 1'b0;
    wait_ren("halt_resume");
    chk("halt_next_addr", bus.imem_addr, old_addr + 32'd4);

    // Reset asserted in the middle of a busy request
    lat = 3;
    step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("mrst_ren", bus.imem_ren, 1'b0);
    chk("mrst_addr", bus.imem_addr, RST_PC);
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_instr", instr, 32'h0);
    chk("mrst_pc", instr_pc, 32'h0);
    chk("mrst_fault", instr_fault, 1'b0);
    chk("mrst_occ", occupancy, 32'h0);
    lat = 0;
    wait_ren("mrst_restart");
    chk("mrst_restart_addr", bus.imem_addr, RST_PC);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
